load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator for the byte-addressed 64-bit data memory. Accepts load/store requests from the
//  pipeline MEM stage and drives the memory's address, write-data and read/write strobes.
//  Extracts and extends sub-doubleword load data. Performs read-modify-write for sub-doubleword
//  stores, because the memory always writes all 8 bytes at the given address.
// PARAMETERS
//  MEM_BYTES  1024  memory size in bytes; an access is legal only if req_addr+7 < MEM_BYTES
// PORTS
//  clk             in   1   clock; all state changes on the rising edge
//  rst_n           in   1   asynchronous active-low reset
//  req_valid       in   1   request present
//  req_ready       out  1   unit idle, request accepted when req_valid&req_ready
//  req_is_store    in   1   1=store, 0=load
//  req_size        in   2   0=byte 1=half 2=word 3=double
//  req_unsigned    in   1   loads: 1=zero-extend, 0=sign-extend; ignored for stores and for size 3
//  req_addr        in   64  byte address
//  req_wdata       in   64  store data, right-justified
//  resp_valid      out  1   response present; held until resp_ready
//  resp_ready      in   1   consumer accepts response
//  resp_rdata      out  64  load result (0 for stores and errors)
//  resp_error      out  1   misaligned or out-of-range access; memory untouched
//  mem_address     out  64  to memory address
//  mem_write_data  out  64  to memory write data
//  mem_write       out  1   memory write strobe; memory writes on the next rising clk
//  mem_read        out  1   memory read enable; mem_read_data valid combinationally
//  mem_read_data   in   64  from memory, bytes [addr+7..addr]
// BEHAVIOUR
//  - FSM states: IDLE, RD, WR, RESP. req_ready=(state==IDLE).
//  - Accept in IDLE: latch addr, size, unsigned, wdata and is_store. Next state:
//      error -> RESP with resp_error=1.
//      load -> RD.
//      store size 3 -> WR.
//      store size<3 -> RD.
//  - Error condition: addr not a multiple of 2^size, OR req_addr+7 >= MEM_BYTES (64-bit compare).
//  - RD: mem_read=1, mem_address=latched addr.
//      Load: capture mem_read_data into the data register, then go to RESP.
//      Store: merge latched wdata low 2^size bytes over mem_read_data, then go to WR.
//  - WR: mem_write=1, mem_address=latched addr, mem_write_data=merged (or full) data; go to RESP.
//  - RESP: resp_valid=1. resp_rdata/resp_error stay stable while waiting.
//      resp_valid&resp_ready -> IDLE.
//      No new request is accepted in the same cycle (req_ready=0 in RESP).
//  - mem_read and mem_write are decoded from the state register only, never both high.
//    Outside RD/WR: mem_address=0, mem_write_data=0.
//  - Load extraction, from byte 0 of the captured data (little-endian):
//      size0 uses [7:0], size1 uses [15:0], size2 uses [31:0], size3 uses all 64 bits.
//      Extension: sign-extend from the top bit unless req_unsigned, then zero-fill.
//  - Latency in cycles, counted from the accept edge to resp_valid:
//      load 2; store double 2; store byte/half/word 3; error 1.
//  - Reset, async: state=IDLE, resp_valid=0, resp_rdata=0, resp_error=0, data registers=0.
//    mem_read and mem_write drop immediately.
//    Reset asserted during WR: the write is aborted and memory is not updated.
//  - req_* inputs are ignored while not IDLE.
//  - resp_ready held low keeps the unit in RESP indefinitely.
// TESTING
//  1. Memory preloaded 0x0102030405060708 at addr 0; load double addr 0
//     -> resp_rdata=0x0102030405060708, resp_valid 2 cycles after accept.
//  2. Byte 0x80 at addr 16; load byte signed addr 16 -> 0xFFFFFFFFFFFFFF80.
//     Same load with unsigned -> 0x0000000000000080.
//  3. Memory 0x1111111111111111 at addr 24; store half 0xABCD addr 24
//     -> exactly one RD then one WR; afterwards load double addr 24 -> 0x111111111111ABCD.
//  4. Load word at addr 6 -> resp_error=1, rdata=0, mem_read and mem_write never asserted.
//     Load double at addr 1020 -> resp_error=1.
//  5. Store double while resp_ready held low 5 cycles
//     -> resp_valid stays 1, req_ready stays 0, and no second mem_write occurs.
//  6. Assert rst_n=0 during WR of a store byte
//     -> mem_write falls immediately, target memory bytes unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: initiator for a byte-addressed 64-bit data memory.
// Loads read 8 bytes, then extract and extend the low 1/2/4/8 bytes.
// Sub-doubleword stores do read-modify-write, because the memory always
// writes all 8 bytes at the given address.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_read_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        is_store_q;

  logic [63:0] align_mask;
  logic [64:0] last_byte;
  logic        req_error;
  logic [63:0] merged;
  logic [63:0] extended;

  // The last-byte sum is one bit wider so addresses near the top of the
  // 64-bit space cannot wrap around and look legal.
  assign align_mask = (64'd1 << req_size) - 64'd1;
  assign last_byte  = {1'b0, req_addr} + 65'd7;
  assign req_error  = ((req_addr & align_mask) != 64'd0) ||
                      (last_byte >= 65'(MEM_BYTES));

  // Store data low bytes laid over the bytes just read from memory
  always_comb begin
    merged = mem_read_data;
    for (int i = 0; i < 8; i++) begin
      if (i < (1 << size_q)) begin
        merged[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  // Load result: low bytes of the read data, sign- or zero-extended
  always_comb begin
    extended = mem_read_data;
    case (size_q)
      2'd0:    extended = {{56{~unsigned_q & mem_read_data[7]}},  mem_read_data[7:0]};
      2'd1:    extended = {{48{~unsigned_q & mem_read_data[15]}}, mem_read_data[15:0]};
      2'd2:    extended = {{32{~unsigned_q & mem_read_data[31]}}, mem_read_data[31:0]};
      default: extended = mem_read_data;
    endcase
  end

  // Request latch, FSM sequencing and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      is_store_q <= 1'b0;
      resp_rdata <= 64'd0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            is_store_q <= req_is_store;
            resp_rdata <= 64'd0;
            resp_error <= req_error;
            if (req_error) begin
              state <= RESP;
            end else if (req_is_store && (req_size == 2'd3)) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (is_store_q) begin
            wdata_q <= merged;
            state   <= WR;
          end else begin
            resp_rdata <= extended;
            state      <= RESP;
          end
        end
        WR: begin
          state <= RESP;
        end
        default: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Handshakes and memory strobes come straight from the state register
  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign mem_read       = (state == RD);
  assign mem_write      = (state == WR);
  assign mem_address    = (mem_read || mem_write) ? addr_q : 64'd0;
  assign mem_write_data = mem_write ? wdata_q : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array memory, a table of directed
// vectors, hand-written hold/reset sequences and random traffic checked
// against a byte-level reference model.
module tb_load_store_unit;

  localparam int MEM_BYTES = 1024;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_read_data;

  logic [7:0] mem      [0:MEM_BYTES-1];
  logic [7:0] init_mem [0:MEM_BYTES-1];
  logic [7:0] ref_mem  [0:MEM_BYTES-1];
  logic       load_init;

  int total;
  int bad;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        un;
    logic [63:0] ad;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  vec_t vecs [21];

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_is_store   (req_is_store),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: bulk preload, otherwise 8-byte writes on the edge after mem_write
  always @(posedge clk) begin
    if (load_init) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_mem[i];
    end else if (mem_write) begin
      for (int i = 0; i < 8; i++) begin
        if (mem_address + 64'(i) < 64'(MEM_BYTES))
          mem[10'(mem_address + 64'(i))] <= mem_write_data[8*i +: 8];
      end
    end
  end

  // Combinational read of bytes [addr+7..addr]
  always_comb begin
    mem_read_data = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (mem_address + 64'(i) < 64'(MEM_BYTES))
        mem_read_data[8*i +: 8] = mem[10'(mem_address + 64'(i))];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model: plain byte arithmetic on ref_mem
  task automatic refModel(input logic st, input logic [1:0] sz, input logic un,
                          input logic [63:0] ad, input logic [63:0] wd,
                          output logic [63:0] e_rd, output logic e_err,
                          output int e_lat, output int e_nrd, output int e_nwr);
    int n;
    logic [63:0] val;
    n = 1 << sz;
    e_err = ((ad % 64'(n)) != 64'd0) || (ad + 64'd7 >= 64'(MEM_BYTES));
    e_rd = 64'd0;
    if (e_err) begin
      e_lat = 1; e_nrd = 0; e_nwr = 0;
    end else if (st) begin
      for (int i = 0; i < n; i++) ref_mem[int'(ad) + i] = wd[8*i +: 8];
      e_lat = (n == 8) ? 2 : 3;
      e_nrd = (n == 8) ? 0 : 1;
      e_nwr = 1;
    end else begin
      val = 64'd0;
      for (int i = 0; i < n; i++) val = val | (64'(ref_mem[int'(ad) + i]) << (8*i));
      if (!un && n < 8 && val[8*n-1]) val = val | (~64'd0 << (8*n));
      e_rd = val;
      e_lat = 2; e_nrd = 1; e_nwr = 0;
    end
  endtask

  // One transaction; hold>0 keeps resp_ready low that many cycles after resp_valid
  task automatic applyStimulus(input string name, input logic st, input logic [1:0] sz,
                               input logic un, input logic [63:0] ad, input logic [63:0] wd,
                               input int hold,
                               output logic [63:0] rd_o, output logic err_o, output int lat_o,
                               output int nrd, output int nwr, output logic idle_o);
    logic [63:0] held;
    nrd = 0; nwr = 0;
    @(negedge clk);
    resp_ready   = (hold == 0);
    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = ad;
    req_wdata    = wd;
    @(posedge clk);
    lat_o = 1;
    #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    while (!resp_valid && lat_o < 20) begin
      if (mem_read)  nrd++;
      if (mem_write) nwr++;
      @(posedge clk);
      lat_o++;
      #1;
    end
    if (!resp_valid) checkOutput({name, "_timeout"}, 64'(resp_valid), 64'd1);
    rd_o  = resp_rdata;
    err_o = resp_error;
    held  = resp_rdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (mem_write) nwr++;
      checkOutput($sformatf("%s_hold%0d_valid", name, h), 64'(resp_valid), 64'd1);
      checkOutput($sformatf("%s_hold%0d_ready", name, h), 64'(req_ready), 64'd0);
      checkOutput($sformatf("%s_hold%0d_rdata", name, h), resp_rdata, held);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    idle_o = req_ready;
  endtask

  task automatic checkTxn(input string name, input logic [63:0] rd, input logic err, input int lat,
                          input int nrd, input int nwr, input logic idle,
                          input logic [63:0] e_rd, input logic e_err, input int e_lat,
                          input int e_nrd, input int e_nwr);
    checkOutput({name, "_rdata"}, rd, e_rd);
    checkOutput({name, "_error"}, 64'(err), 64'(e_err));
    checkOutput({name, "_latency"}, 64'(lat), 64'(e_lat));
    checkOutput({name, "_reads"}, 64'(nrd), 64'(e_nrd));
    checkOutput({name, "_writes"}, 64'(nwr), 64'(e_nwr));
    checkOutput({name, "_idle"}, 64'(idle), 64'd1);
  endtask

  // Model the access, run it on the DUT and compare everything
  task automatic runModeled(input string name, input logic st, input logic [1:0] sz, input logic un,
                            input logic [63:0] ad, input logic [63:0] wd, input int hold);
    logic [63:0] e_rd, rd;
    logic e_err, err, idle;
    int e_lat, e_nrd, e_nwr, lat, nrd, nwr;
    refModel(st, sz, un, ad, wd, e_rd, e_err, e_lat, e_nrd, e_nwr);
    applyStimulus(name, st, sz, un, ad, wd, hold, rd, err, lat, nrd, nwr, idle);
    checkTxn(name, rd, err, lat, nrd, nwr, idle, e_rd, e_err, e_lat, e_nrd, e_nwr);
  endtask

  initial begin
    logic [63:0] rd, m_rd;
    logic err, idle, m_err;
    int lat, nrd, nwr, m_lat, m_nrd, m_nwr, diffs;
    logic st, un;
    logic [1:0] sz;
    logic [63:0] ad, wd;
    int hold;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    load_init = 1'b1;
    resp_ready = 1'b1;
    req_valid = 1'b0;
    req_is_store = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 64'd0;
    req_wdata = 64'd0;

    for (int i = 0; i < MEM_BYTES; i++) init_mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) init_mem[i] = 8'(8 - i);
    init_mem[16] = 8'h80;
    for (int i = 24; i < 32; i++) init_mem[i] = 8'h11;
    init_mem[64] = 8'h77;
    for (int i = 65; i < 72; i++) init_mem[i] = 8'h66;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_mem[i];

    //            st    sz    un    addr      wdata                   exp_rdata               err  lat rd wr
    vecs[0]  = '{1'b0, 2'd3, 1'b0, 64'd0,    64'd0,                  64'h0102030405060708,   1'b0, 2, 1, 0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 64'd16,   64'd0,                  64'hFFFFFFFFFFFFFF80,   1'b0, 2, 1, 0};
    vecs[2]  = '{1'b0, 2'd0, 1'b1, 64'd16,   64'd0,                  64'h0000000000000080,   1'b0, 2, 1, 0};
    vecs[3]  = '{1'b1, 2'd1, 1'b0, 64'd24,   64'hDEADBEEF0000ABCD,   64'd0,                  1'b0, 3, 1, 1};
    vecs[4]  = '{1'b0, 2'd3, 1'b0, 64'd24,   64'd0,                  64'h111111111111ABCD,   1'b0, 2, 1, 0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 64'd6,    64'd0,                  64'd0,                  1'b1, 1, 0, 0};
    vecs[6]  = '{1'b0, 2'd3, 1'b0, 64'd1020, 64'd0,                  64'd0,                  1'b1, 1, 0, 0};
    vecs[7]  = '{1'b0, 2'd3, 1'b0, 64'd1016, 64'd0,                  64'd0,                  1'b0, 2, 1, 0};
    vecs[8]  = '{1'b0, 2'd0, 1'b1, 64'd1017, 64'd0,                  64'd0,                  1'b1, 1, 0, 0};
    vecs[9]  = '{1'b0, 2'd0, 1'b1, 64'd1016, 64'd0,                  64'd0,                  1'b0, 2, 1, 0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 64'd17,   64'd0,                  64'd0,                  1'b1, 1, 0, 0};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 64'd32,   64'h1234567889ABCDEF,   64'd0,                  1'b0, 3, 1, 1};
    vecs[12] = '{1'b0, 2'd2, 1'b0, 64'd32,   64'd0,                  64'hFFFFFFFF89ABCDEF,   1'b0, 2, 1, 0};
    vecs[13] = '{1'b0, 2'd2, 1'b1, 64'd32,   64'd0,                  64'h0000000089ABCDEF,   1'b0, 2, 1, 0};
    vecs[14] = '{1'b0, 2'd3, 1'b0, 64'd32,   64'd0,                  64'h0000000089ABCDEF,   1'b0, 2, 1, 0};
    vecs[15] = '{1'b0, 2'd1, 1'b0, 64'd0,    64'd0,                  64'h0000000000000708,   1'b0, 2, 1, 0};
    vecs[16] = '{1'b1, 2'd3, 1'b0, 64'd40,   64'hCAFEF00D12345678,   64'd0,                  1'b0, 2, 0, 1};
    vecs[17] = '{1'b0, 2'd3, 1'b0, 64'd40,   64'd0,                  64'hCAFEF00D12345678,   1'b0, 2, 1, 0};
    vecs[18] = '{1'b1, 2'd0, 1'b0, 64'd1017, 64'h00000000000000EE,   64'd0,                  1'b1, 1, 0, 0};
    vecs[19] = '{1'b1, 2'd3, 1'b0, 64'd44,   64'hFFFFFFFFFFFFFFFF,   64'd0,                  1'b1, 1, 0, 0};
    vecs[20] = '{1'b0, 2'd3, 1'b1, 64'd40,   64'd0,                  64'hCAFEF00D12345678,   1'b0, 2, 1, 0};

    #1;
    checkOutput("reset_req_ready",  64'(req_ready),  64'd1);
    checkOutput("reset_resp_valid", 64'(resp_valid), 64'd0);
    checkOutput("reset_resp_rdata", resp_rdata,      64'd0);
    checkOutput("reset_resp_error", 64'(resp_error), 64'd0);
    checkOutput("reset_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    checkOutput("reset_mem_address", mem_address,    64'd0);
    @(posedge clk);
    @(negedge clk);
    load_init = 1'b0;
    rst_n = 1'b1;

    for (int k = 0; k < 21; k++) begin
      refModel(vecs[k].st, vecs[k].sz, vecs[k].un, vecs[k].ad, vecs[k].wd,
               m_rd, m_err, m_lat, m_nrd, m_nwr);
      applyStimulus($sformatf("vec%0d", k), vecs[k].st, vecs[k].sz, vecs[k].un,
                    vecs[k].ad, vecs[k].wd, 0, rd, err, lat, nrd, nwr, idle);
      checkTxn($sformatf("vec%0d", k), rd, err, lat, nrd, nwr, idle,
               vecs[k].exp_rd, vecs[k].exp_err, vecs[k].exp_lat, vecs[k].exp_nrd, vecs[k].exp_nwr);
    end

    // Store double with resp_ready held low for 5 cycles
    runModeled("hold_store", 1'b1, 2'd3, 1'b0, 64'd48, 64'hA5A55A5A0F0FF0F0, 5);
    runModeled("hold_readback", 1'b0, 2'd3, 1'b0, 64'd48, 64'd0, 0);

    // Reset asserted mid-WR of a store byte aborts the write
    @(negedge clk);
    req_valid = 1'b1;
    req_is_store = 1'b1;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 64'd64;
    req_wdata = 64'h000000000000005A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_wr_entered", 64'(mem_write), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_write_drop", 64'(mem_write),  64'd0);
    checkOutput("rst_wr_ready",      64'(req_ready),  64'd1);
    checkOutput("rst_wr_valid",      64'(resp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_wr_ready_after", 64'(req_ready), 64'd1);
    checkOutput("rst_wr_mem64", 64'(mem[64]), 64'h77);
    runModeled("rst_wr_readback", 1'b0, 2'd3, 1'b0, 64'd64, 64'd0, 0);

    // Random traffic against the reference model
    for (int t = 0; t < 200; t++) begin
      st = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      un = 1'($urandom_range(0, 1));
      ad = 64'($urandom_range(0, MEM_BYTES - 1));
      if ($urandom_range(0, 3) != 0) ad = ad & ~((64'd1 << sz) - 64'd1);
      wd = {$urandom, $urandom};
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      runModeled($sformatf("rand%0d", t), st, sz, un, ad, wd, hold);
    end

    diffs = 0;
    for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) diffs++;
    checkOutput("mem_image_diffs", 64'(diffs), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
